// File: rtl/neuron_layer_engine.sv
// Ten-neuron layer engine: streams buffer reads and multiply-accumulates them
// against ten parallel weights plus a constant-127 bias. The sums then go
// through ReLU and saturation, and the results are written back with a write pulse.
module neuron_layer_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  base,
  input  logic [6:0]  num_in,
  input  logic        dst,
  input  logic [7:0]  R,
  input  logic [79:0] w_bus,
  output logic [6:0]  readloc,
  output logic [6:0]  wsel,
  output logic        write,
  output logic        writeloc,
  output logic [7:0]  n1o,
  output logic [7:0]  n2o,
  output logic [7:0]  n3o,
  output logic [7:0]  n4o,
  output logic [7:0]  n5o,
  output logic [7:0]  n6o,
  output logic [7:0]  n7o,
  output logic [7:0]  n8o,
  output logic [7:0]  n9o,
  output logic [7:0]  n10o,
  output logic        busy,
  output logic        done
);

  localparam logic [6:0] BIAS_ADDR = 7'd62;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_ACT,
    S_WRITE
  } state_t;

  state_t state;
  state_t state_n;

  logic [6:0]         base_q;
  logic [6:0]         num_q;
  logic               dst_q;
  logic [6:0]         idx;
  logic               valid;
  logic signed [20:0] acc   [10];
  logic signed [15:0] prod  [10];
  logic        [7:0]  n_q   [10];

  // Takes acc >>> 7. A negative value gives 0, and anything above 127 saturates to 127.
  function automatic logic [7:0] relu_sat(input logic signed [13:0] q);
    logic [7:0] r;
    if (q[13])
      r = 8'd0;
    else if (|q[12:7])
      r = 8'd127;
    else
      r = {1'b0, q[6:0]};
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      state <= S_IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (start) state_n = S_ISSUE;
      S_ISSUE: if (idx == num_q) state_n = S_DRAIN;
      S_DRAIN: state_n = S_ACT;
      S_ACT:   state_n = S_WRITE;
      S_WRITE: state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != S_IDLE);
    write   = 1'b0;
    done    = 1'b0;
    readloc = 7'd0;
    wsel    = 7'd0;
    case (state)
      S_ISSUE: begin
        readloc = (idx == num_q) ? BIAS_ADDR : base_q + idx;
        wsel    = idx;
      end
      S_WRITE: begin
        write = 1'b1;
        done  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      prod[k] = $signed({{8{R[7]}}, R}) *
                $signed({{8{w_bus[8*k+7]}}, w_bus[8*k +: 8]});
    end
  end

  // R and w_bus trail the issued address by one cycle, so valid marks the cycle when they line up.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= 7'd0;
      num_q  <= 7'd0;
      dst_q  <= 1'b0;
      idx    <= 7'd0;
      valid  <= 1'b0;
      for (int k = 0; k < 10; k++) begin
        acc[k] <= 21'sd0;
        n_q[k] <= 8'd0;
      end
    end else begin
      valid <= (state == S_ISSUE);
      if (state == S_IDLE && start) begin
        base_q <= base;
        num_q  <= num_in;
        dst_q  <= dst;
        idx    <= 7'd0;
        for (int k = 0; k < 10; k++)
          acc[k] <= 21'sd0;
      end else begin
        if (state == S_ISSUE)
          idx <= idx + 7'd1;
        if (valid) begin
          for (int k = 0; k < 10; k++)
            acc[k] <= acc[k] + {{5{prod[k][15]}}, prod[k]};
        end
      end
      if (state == S_ACT) begin
        for (int k = 0; k < 10; k++)
          n_q[k] <= relu_sat(acc[k][20:7]);
      end
    end
  end

  assign writeloc = dst_q;
  assign n1o  = n_q[0];
  assign n2o  = n_q[1];
  assign n3o  = n_q[2];
  assign n4o  = n_q[3];
  assign n5o  = n_q[4];
  assign n6o  = n_q[5];
  assign n7o  = n_q[6];
  assign n8o  = n_q[7];
  assign n9o  = n_q[8];
  assign n10o = n_q[9];

endmodule
